axi_addr_arbiter: RTL and testbench

AXI_ADDR_ARBITER -- requirements
Module: axi_addr_arbiter

---
 rtl/axi_addr_arbiter.sv | 104 ++++++++++
 tb/tb_axi_addr_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/axi_addr_arbiter.sv
// axi_addr_arbiter: IDLE/BUSY AXI address-channel grant arbiter with hold timeout; define AXI_ARB_RR_EN for round-robin master select
module axi_addr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int WRITE_PRIORITY = 1,
  parameter int MAX_HOLD       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         arvalid_m,
  input  logic [NUM_MASTERS-1:0]         awvalid_m,
  input  logic                           txn_done,
  output logic [NUM_MASTERS-1:0]         arvalid_sel,
  output logic [NUM_MASTERS-1:0]         awvalid_sel,
  output logic                           grant_valid,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                           grant_write,
  output logic                           timeout
);
  localparam int IW = $clog2(NUM_MASTERS);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state;
  logic [7:0] r_hold, w_hold;
  logic [NUM_MASTERS-1:0] r_ar, r_aw, w_ar, w_aw, w_req, w_oh;
  logic [IW-1:0] r_id, w_id, w_pick;
  logic r_gw, w_gw, r_to, w_to, w_any, w_dir_wr;
  assign w_any    = |{arvalid_m, awvalid_m};
  assign w_dir_wr = (WRITE_PRIORITY != 0) ? |awvalid_m : ~|arvalid_m;
  assign w_req    = w_dir_wr ? awvalid_m : arvalid_m;
  assign w_oh     = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_pick;
`ifdef AXI_ARB_RR_EN
  logic [IW-1:0] r_ptr;
  logic [IW:0] w_sum;
  always_comb begin
    w_pick = '0;
    w_sum  = '0;
    for (int k = NUM_MASTERS-1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      w_sum = (w_sum >= (IW+1)'(NUM_MASTERS)) ? w_sum - (IW+1)'(NUM_MASTERS) : w_sum;
      if (w_req[w_sum[IW-1:0]]) w_pick = w_sum[IW-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (r_state == IDLE && w_any) r_ptr <= (w_pick == IW'(NUM_MASTERS-1)) ? '0 : w_pick + IW'(1);
  end
`else
  always_comb begin
    w_pick = '0;
    for (int i = NUM_MASTERS-1; i >= 0; i--) if (w_req[i]) w_pick = IW'(i);
  end
`endif
  always_comb begin
    w_state = r_state;
    w_hold  = r_hold;
    w_ar    = r_ar;
    w_aw    = r_aw;
    w_id    = r_id;
    w_gw    = r_gw;
    w_to    = 1'b0;
    if (r_state == IDLE) begin
      w_state = w_any ? BUSY : IDLE;
      w_hold  = '0;
      w_ar    = (w_any && !w_dir_wr) ? w_oh : '0;
      w_aw    = (w_any && w_dir_wr) ? w_oh : '0;
      w_id    = w_any ? w_pick : '0;
      w_gw    = w_any & w_dir_wr;
    end else if (txn_done || r_hold == 8'(MAX_HOLD-1)) begin
      w_state = IDLE;
      w_hold  = '0;
      w_ar    = '0;
      w_aw    = '0;
      w_id    = '0;
      w_gw    = 1'b0;
      w_to    = ~txn_done;
    end else begin
      w_hold  = r_hold + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_ar    <= '0;
      r_aw    <= '0;
      r_id    <= '0;
      r_gw    <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_hold  <= w_hold;
      r_ar    <= w_ar;
      r_aw    <= w_aw;
      r_id    <= w_id;
      r_gw    <= w_gw;
      r_to    <= w_to;
    end
  end
  assign arvalid_sel = r_ar;
  assign awvalid_sel = r_aw;
  assign grant_valid = |{r_ar, r_aw};
  assign grant_id    = r_id;
  assign grant_write = r_gw;
  assign timeout     = r_to;
endmodule

// File: tb/tb_axi_addr_arbiter.sv
// tb_axi_addr_arbiter: directed scoreboard bench for write-priority and read-priority arbiter instances
module tb_axi_addr_arbiter;
  logic clk = 1'b0, rst = 1'b1, txn_done = 1'b0;
  logic [1:0] ar = '0, aw = '0;
  logic [1:0] ar_sel, aw_sel, rd_ar_sel, rd_aw_sel;
  logic gv, gid, gw, to, rd_gv, rd_gid, rd_gw, rd_to;
  int n_tests = 0, n_fail = 0;
  logic [7:0] q0[$], q1[$];
  string t0[$], t1[$];
  localparam logic [7:0] ZERO = 8'b0;
  axi_addr_arbiter #(.NUM_MASTERS(2), .WRITE_PRIORITY(1), .MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .arvalid_m(ar), .awvalid_m(aw), .txn_done(txn_done),
    .arvalid_sel(ar_sel), .awvalid_sel(aw_sel), .grant_valid(gv), .grant_id(gid),
    .grant_write(gw), .timeout(to));
  axi_addr_arbiter #(.NUM_MASTERS(2), .WRITE_PRIORITY(0), .MAX_HOLD(16)) dut_rd (
    .clk(clk), .rst(rst), .arvalid_m(ar), .awvalid_m(aw), .txn_done(txn_done),
    .arvalid_sel(rd_ar_sel), .awvalid_sel(rd_aw_sel), .grant_valid(rd_gv), .grant_id(rd_gid),
    .grant_write(rd_gw), .timeout(rd_to));
  always #5 clk = ~clk;
  function automatic logic [7:0] pk(logic [1:0] a, logic [1:0] w, logic v, logic i, logic g, logic t);
    return {a, w, v, i, g, t};
  endfunction
  task automatic exp0(string t, logic [7:0] e);
    q0.push_back(e);
    t0.push_back(t);
  endtask
  task automatic exp1(string t, logic [7:0] e);
    q1.push_back(e);
    t1.push_back(t);
  endtask
  task automatic check(string t, logic [7:0] obs, logic [7:0] e);
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed={ar,aw,gv,id,gw,to}=%b expected=%b", t, obs, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    while (q0.size() > 0) check(t0.pop_front(), {ar_sel, aw_sel, gv, gid, gw, to}, q0.pop_front());
    while (q1.size() > 0) check(t1.pop_front(), {rd_ar_sel, rd_aw_sel, rd_gv, rd_gid, rd_gw, rd_to}, q1.pop_front());
  endtask
  initial begin
    ar = 2'b11;
    aw = 2'b11;
    exp0("rst_c1", ZERO);
    exp1("rst_c1_rd", ZERO);
    step();
    exp0("rst_c2", ZERO);
    exp1("rst_c2_rd", ZERO);
    step();
    rst = 1'b0;
    exp0("post_rst_grant", pk(2'b00, 2'b01, 1, 0, 1, 0));
    exp1("post_rst_grant_rd", pk(2'b01, 2'b00, 1, 0, 0, 0));
    step();
    ar = '0;
    aw = '0;
    txn_done = 1'b1;
    exp0("post_rst_done", ZERO);
    exp1("post_rst_done_rd", ZERO);
    step();
    txn_done = 1'b0;
    ar = 2'b01;
    exp0("rd_grant_c1", pk(2'b01, 2'b00, 1, 0, 0, 0));
    step();
    for (int c = 2; c <= 5; c++) begin
      ar = 2'b00;
      aw = 2'b10;
      exp0($sformatf("rd_hold_c%0d", c), pk(2'b01, 2'b00, 1, 0, 0, 0));
      step();
    end
    aw = '0;
    txn_done = 1'b1;
    exp0("rd_done_c6", ZERO);
    step();
    txn_done = 1'b0;
    ar = 2'b01;
    aw = 2'b10;
    exp0("wr_prio", pk(2'b00, 2'b10, 1, 1, 1, 0));
    exp1("rd_prio", pk(2'b01, 2'b00, 1, 0, 0, 0));
    step();
    ar = '0;
    aw = '0;
    txn_done = 1'b1;
    exp0("prio_done", ZERO);
    exp1("prio_done_rd", ZERO);
    step();
    txn_done = 1'b0;
    rst = 1'b1;
    exp0("rst_idle", ZERO);
    step();
    rst = 1'b0;
    ar = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic id;
`ifdef AXI_ARB_RR_EN
      id = i[0];
`else
      id = 1'b0;
`endif
      exp0($sformatf("seq_grant%0d", i), pk(id ? 2'b10 : 2'b01, 2'b00, 1, id, 0, 0));
      step();
      txn_done = 1'b1;
      exp0($sformatf("seq_done%0d", i), ZERO);
      step();
      txn_done = 1'b0;
    end
    ar = 2'b00;
    exp0("seq_idle", ZERO);
    step();
    ar = 2'b01;
    exp0("to_c1", pk(2'b01, 2'b00, 1, 0, 0, 0));
    step();
    ar = 2'b00;
    for (int c = 2; c <= 16; c++) begin
      exp0($sformatf("to_hold_c%0d", c), pk(2'b01, 2'b00, 1, 0, 0, 0));
      step();
    end
    exp0("timeout_c17", pk(2'b00, 2'b00, 0, 0, 0, 1));
    step();
    exp0("timeout_c18", ZERO);
    step();
    ar = 2'b01;
    exp0("late_c1", pk(2'b01, 2'b00, 1, 0, 0, 0));
    step();
    ar = 2'b00;
    for (int c = 2; c <= 16; c++) begin
      exp0($sformatf("late_hold_c%0d", c), pk(2'b01, 2'b00, 1, 0, 0, 0));
      step();
    end
    txn_done = 1'b1;
    exp0("late_done_no_to", ZERO);
    step();
    txn_done = 1'b0;
    exp0("late_after", ZERO);
    step();
    ar = 2'b01;
    exp0("mid_c1", pk(2'b01, 2'b00, 1, 0, 0, 0));
    step();
    ar = 2'b00;
    for (int c = 2; c <= 4; c++) begin
      exp0($sformatf("mid_hold_c%0d", c), pk(2'b01, 2'b00, 1, 0, 0, 0));
      step();
    end
    rst = 1'b1;
    ar = 2'b11;
    txn_done = 1'b1;
    exp0("mid_rst_c5", ZERO);
    step();
    rst = 1'b0;
    txn_done = 1'b0;
    exp0("ptr_reset_grant", pk(2'b01, 2'b00, 1, 0, 0, 0));
    step();
    ar = 2'b00;
    txn_done = 1'b1;
    exp0("final_idle", ZERO);
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
